bit_serial_core_p: RTL and testbench

//  Parametrised bit-serial execution core: XLEN-bit datapath, NREGS-entry register file, 1 ALU bit/cycle, LSB first.

---
 rtl/bsc_pkg.sv | 35 +++
 rtl/alu_1bit.sv | 38 +++
 rtl/bsc_regfile.sv | 42 ++++
 rtl/bit_serial_core_p.sv | 166 ++++++++++++++++
 tb/tb_bit_serial_core_p.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsc_pkg.sv
// Shared definitions for the bit-serial core: opcodes, FSM states and
// instruction field offsets.
package bsc_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Layout from the MSB: opcode, rd, rs1, rs2 (rs2 in the LSBs)
    function automatic int op_lsb(input int aw);
        return 3 * aw;
    endfunction

    function automatic int rd_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int rs1_lsb(input int aw);
        return aw;
    endfunction

    function automatic int rs2_lsb(input int aw);
        return 0 * aw;
    endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit slice ALU: add/sub via carry chain, bitwise ops, move.
// Carry passes through untouched for non-arithmetic ops.
module alu_1bit
    import bsc_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_cin,
    input  logic [3:0] i_op,
    output logic       o_y,
    output logic       o_cout
);

    logic w_b;
    logic w_sum;
    logic w_cgen;

    assign w_b    = (i_op == OP_SUB) ? ~i_b : i_b;
    assign w_sum  = i_a ^ w_b ^ i_cin;
    assign w_cgen = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);

    always_comb begin
        o_y    = 1'b0;
        o_cout = i_cin;
        unique case (i_op)
            OP_ADD, OP_SUB: begin
                o_y    = w_sum;
                o_cout = w_cgen;
            end
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_MOV:  o_y = i_a;
            default: o_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/bsc_regfile.sv
// NREGS x XLEN register file with two bit-select read ports, one
// parallel write port and a debug read port; r0 is hardwired to zero.
module bsc_regfile
    import bsc_pkg::*;
#(
    parameter int XLEN  = 8,
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [AW-1:0]   i_ra_addr,
    input  logic [CW-1:0]   i_ra_bit,
    output logic            o_ra_q,
    input  logic [AW-1:0]   i_rb_addr,
    input  logic [CW-1:0]   i_rb_bit,
    output logic            o_rb_q,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_dbg_addr,
    output logic [XLEN-1:0] o_dbg_rdata
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_q = (i_ra_addr == '0) ? 1'b0 : r_mem[i_ra_addr][i_ra_bit];
    assign o_rb_q = (i_rb_addr == '0) ? 1'b0 : r_mem[i_rb_addr][i_rb_bit];
    assign o_dbg_rdata = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/bit_serial_core_p.sv
// Bit-serial execution core: one ALU bit per cycle, LSB first.
// Optional zero/carry flags are built when BSC_FLAGS_EN is defined.
module bit_serial_core_p
    import bsc_pkg::*;
#(
    parameter int XLEN  = 8,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS),
    localparam int IW   = 4 + 3 * AW
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [IW-1:0]   instr,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    input  logic            dbg_we,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic [XLEN-1:0] dbg_rdata,
    output logic            flag_z,
    output logic            flag_c
);

    localparam int CW  = $clog2(XLEN);
    localparam int OPL = op_lsb(AW);
    localparam int RDL = rd_lsb(AW);
    localparam int R1L = rs1_lsb(AW);
    localparam int R2L = rs2_lsb(AW);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_op;
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_rs1;
    logic [AW-1:0]   r_rs2;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic [XLEN-1:0] r_shift;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_last;
    logic            w_op_wr;
    logic            w_a;
    logic            w_b;
    logic            w_y;
    logic            w_cout;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [XLEN-1:0] w_wdata;

    assign w_accept = (r_state == S_IDLE) && instr_valid;
    assign w_last   = (r_cnt == CW'(XLEN - 1));
    assign w_op_wr  = (r_op <= OP_MOV);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  if (w_last) w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign instr_ready = (r_state == S_IDLE);
    assign busy        = (r_state == S_EXEC) || (r_state == S_WB);
    assign done        = (r_state == S_WB);
    assign result      = r_result;

    // Debug writes and writeback never collide: one is IDLE-only, one WB-only
    assign w_we    = ((r_state == S_IDLE) && dbg_we) ||
                     ((r_state == S_WB) && w_op_wr);
    assign w_waddr = (r_state == S_WB) ? r_rd : dbg_addr;
    assign w_wdata = (r_state == S_WB) ? r_shift : dbg_wdata;

    bsc_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk         (clk),
        .rstn        (rstn),
        .i_ra_addr   (r_rs1),
        .i_ra_bit    (r_cnt),
        .o_ra_q      (w_a),
        .i_rb_addr   (r_rs2),
        .i_rb_bit    (r_cnt),
        .o_rb_q      (w_b),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_rdata (dbg_rdata)
    );

    alu_1bit u_alu (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (r_carry),
        .i_op   (r_op),
        .o_y    (w_y),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_shift  <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= instr[OPL +: 4];
                        r_rd    <= instr[RDL +: AW];
                        r_rs1   <= instr[R1L +: AW];
                        r_rs2   <= instr[R2L +: AW];
                        r_cnt   <= '0;
                        r_carry <= (instr[OPL +: 4] == OP_SUB);
                    end
                end
                S_EXEC: begin
                    r_shift <= {w_y, r_shift[XLEN-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_WB: begin
                    if (w_op_wr) r_result <= r_shift;
                end
                default: ;
            endcase
        end
    end

`ifdef BSC_FLAGS_EN
    logic r_fz;
    logic r_fc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fz <= 1'b0;
            r_fc <= 1'b0;
        end else if ((r_state == S_WB) && w_op_wr) begin
            r_fz <= (r_shift == '0);
            r_fc <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? r_carry : 1'b0;
        end
    end

    assign flag_z = r_fz;
    assign flag_c = r_fc;
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_core_p.sv
// Directed-vector bench for bit_serial_core_p (XLEN=8, NREGS=8).
// Expected values are hand-computed and tracked in a small register model.
module tb_bit_serial_core_p;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_valid;
    logic        instr_ready;
    logic [12:0] instr;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic        dbg_we;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_wdata;
    logic [7:0]  dbg_rdata;
    logic        flag_z;
    logic        flag_c;

    bit_serial_core_p #(.XLEN(8), .NREGS(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [7:0] v1;
        logic [7:0] v2;
        logic [7:0] exp;
        logic       z;
        logic       c;
    } vec_t;

    vec_t       vt [9];
    int         nvec = 0;
    int         nfail = 0;
    logic [7:0] mdl [8];
    logic [7:0] exp_res;
    logic       exp_z;
    logic       exp_c;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic dbg_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        dbg_we    = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
        @(negedge clk);
        dbg_we = 1'b0;
        if (a != 3'd0) mdl[a] = d;
    endtask

    task automatic chk_regs(input string nm);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk($sformatf("%s r%0d", nm, i), dbg_rdata, mdl[i]);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       output int lat, output logic seen);
        @(negedge clk);
        instr       = {op, rd, rs1, rs2};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        seen = done;
        @(negedge clk);
    endtask

    task automatic chk_flags(input string nm);
        chk({nm, " flag_z"}, flag_z, exp_z);
        chk({nm, " flag_c"}, flag_c, exp_c);
    endtask

    initial begin
        int         lat;
        logic       seen;
        logic [7:0] rv;

        vt[0] = '{4'd0, 3'd3, 3'd1, 3'd2, 8'h35, 8'h0F, 8'h44, 1'b0, 1'b0};
        vt[1] = '{4'd1, 3'd4, 3'd2, 3'd1, 8'h35, 8'h0F, 8'hDA, 1'b0, 1'b0};
        vt[2] = '{4'd1, 3'd4, 3'd1, 3'd1, 8'h35, 8'h0F, 8'h00, 1'b1, 1'b1};
        vt[3] = '{4'd0, 3'd5, 3'd1, 3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vt[4] = '{4'd2, 3'd6, 3'd1, 3'd2, 8'h35, 8'h0F, 8'h05, 1'b0, 1'b0};
        vt[5] = '{4'd3, 3'd7, 3'd1, 3'd2, 8'h35, 8'h0F, 8'h3F, 1'b0, 1'b0};
        vt[6] = '{4'd4, 3'd3, 3'd1, 3'd2, 8'h35, 8'h0F, 8'h3A, 1'b0, 1'b0};
        vt[7] = '{4'd5, 3'd4, 3'd1, 3'd2, 8'h35, 8'h0F, 8'h35, 1'b0, 1'b0};
        vt[8] = '{4'd0, 3'd1, 3'd1, 3'd2, 8'h35, 8'h0F, 8'h44, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        exp_res = 8'h00;
        exp_z   = 1'b0;
        exp_c   = 1'b0;

        rstn        = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_we      = 1'b0;
        dbg_addr    = '0;
        dbg_wdata   = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        chk("reset ready", instr_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 8'h00);
        chk_flags("reset");
        chk_regs("reset");

        for (int v = 0; v < 9; v++) begin
            dbg_wr(3'd1, vt[v].v1);
            dbg_wr(3'd2, vt[v].v2);
            run(vt[v].op, vt[v].rd, vt[v].rs1, vt[v].rs2, lat, seen);
            chk($sformatf("v%0d done", v), seen, 1'b1);
            chk($sformatf("v%0d latency", v), lat, 9);
            if (vt[v].rd != 3'd0) mdl[vt[v].rd] = vt[v].exp;
            exp_res = vt[v].exp;
`ifdef BSC_FLAGS_EN
            exp_z = vt[v].z;
            exp_c = vt[v].c;
`endif
            chk($sformatf("v%0d result", v), result, exp_res);
            chk_flags($sformatf("v%0d", v));
            chk_regs($sformatf("v%0d", v));
        end

        // Reset in the middle of EXEC drops the instruction
        dbg_wr(3'd1, 8'h35);
        dbg_wr(3'd2, 8'h0F);
        @(negedge clk);
        instr       = {4'd0, 3'd3, 3'd1, 3'd2};
        instr_valid = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) begin
            seen = seen | done;
            @(negedge clk);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        exp_res = 8'h00;
        exp_z   = 1'b0;
        exp_c   = 1'b0;
        repeat (12) begin
            seen = seen | done;
            @(negedge clk);
        end
        chk("midreset no done", seen, 1'b0);
        chk("midreset ready", instr_ready, 1'b1);
        chk("midreset busy", busy, 1'b0);
        chk("midreset result", result, 8'h00);
        chk_flags("midreset");
        chk_regs("midreset");

        // Held valid during EXEC: stalls, debug write ignored
        dbg_wr(3'd1, 8'h35);
        dbg_wr(3'd2, 8'h0F);
        @(negedge clk);
        instr       = {4'd0, 3'd3, 3'd1, 3'd2};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr     = {4'd4, 3'd6, 3'd1, 3'd2};
        dbg_we    = 1'b1;
        dbg_addr  = 3'd2;
        dbg_wdata = 8'hAA;
        chk("busy ready", instr_ready, 1'b0);
        chk("busy busy", busy, 1'b1);
        @(negedge clk);
        dbg_we = 1'b0;
        lat = 2;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("busy first done", done, 1'b1);
        chk("busy first latency", lat, 9);
        @(negedge clk);
        chk("busy idle ready", instr_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("busy second done", done, 1'b1);
        @(negedge clk);
        mdl[3]  = 8'h44;
        mdl[6]  = 8'h3A;
        exp_res = 8'h3A;
`ifdef BSC_FLAGS_EN
        exp_z = 1'b0;
        exp_c = 1'b0;
`endif
        chk("busy result", result, exp_res);
        chk_flags("busy");
        chk_regs("busy");

        // r0 stays zero on debug write and on writeback
        dbg_wr(3'd0, 8'h55);
        dbg_addr = 3'd0;
        #1;
        rv = dbg_rdata;
        chk("dbg r0", rv, 8'h00);
        run(4'd0, 3'd0, 3'd1, 3'd2, lat, seen);
        chk("r0 done", seen, 1'b1);
        exp_res = 8'h44;
        chk("r0 result", result, exp_res);
        chk_regs("r0");

        // NOP: full EXEC, done pulses, nothing changes
        run(4'hF, 3'd3, 3'd1, 3'd2, lat, seen);
        chk("nop done", seen, 1'b1);
        chk("nop latency", lat, 9);
        chk("nop result", result, exp_res);
        chk_flags("nop");
        chk_regs("nop");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
